// File: rtl/aes_key_sched_ctrl_if.sv
// Round-key stream from the key scheduler to the inverse-cipher datapath.
// A beat transfers on any rising edge where out_valid && out_ready; while out_valid is high and out_ready is low, out_data/out_round/out_last hold stable.
interface aes_key_sched_ctrl_if;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_round,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_round,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion (one round key per clock through one SubWord unit)
// with an 11-entry key store streamed out in reverse (decrypt) or forward order.
module aes_key_sched_ctrl #(
    parameter bit REVERSE_ORDER = 1'b1,
    parameter int NR            = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_load,
    input  logic [127:0]                key_in,
    input  logic                        stream_start,
    output logic                        busy,
    output logic                        keys_ready,
    output logic [1:0]                  dbg_state,
    aes_key_sched_ctrl_if.master        out_if
);

    if (NR != 10) begin : g_bad_nr
        $error("aes_key_sched_ctrl: NR must be 10 for AES-128");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    localparam logic [3:0] FIRST_IDX = REVERSE_ORDER ? 4'(NR) : 4'd0;
    localparam logic [3:0] LAST_IDX  = REVERSE_ORDER ? 4'd0   : 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] rk_d [0:NR];
    logic         busy_q, busy_d;
    logic         keys_ready_q, keys_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [3:0]   out_round_q, out_round_d;
    logic         out_last_q, out_last_d;

    logic [3:0]   prev_idx;
    logic [127:0] prev_key;
    logic [31:0]  temp_word;
    logic [31:0]  w4, w5, w6, w7;
    logic [127:0] next_key;
    logic [3:0]   step_idx;

    // Single SubWord unit: round key cnt is derived from round key cnt-1.
    always_comb begin
        prev_idx  = cnt_q - 4'd1;
        prev_key  = rk_q[prev_idx];
        temp_word = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon(cnt_q), 24'h000000};
        w4        = prev_key[127:96] ^ temp_word;
        w5        = prev_key[95:64]  ^ w4;
        w6        = prev_key[63:32]  ^ w5;
        w7        = prev_key[31:0]   ^ w6;
        next_key  = {w4, w5, w6, w7};
        step_idx  = REVERSE_ORDER ? (out_round_q - 4'd1) : (out_round_q + 4'd1);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rk_d         = rk_q;
        busy_d       = busy_q;
        keys_ready_d = keys_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_round_d  = out_round_q;
        out_last_d   = out_last_q;

        // A new key overrides everything, including an in-flight stream.
        if (key_load) begin
            rk_d[0]      = key_in;
            cnt_d        = 4'd1;
            state_d      = ST_EXPAND;
            busy_d       = 1'b1;
            keys_ready_d = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
        end else begin
            case (state_q)
                ST_EXPAND: begin
                    rk_d[cnt_q] = next_key;
                    cnt_d       = cnt_q + 4'd1;
                    if (cnt_q == 4'(NR)) begin
                        state_d      = ST_READY;
                        cnt_d        = 4'd0;
                        busy_d       = 1'b0;
                        keys_ready_d = 1'b1;
                    end
                end
                ST_READY: begin
                    if (stream_start) begin
                        state_d     = ST_STREAM;
                        out_valid_d = 1'b1;
                        out_data_d  = rk_q[FIRST_IDX];
                        out_round_d = FIRST_IDX;
                        out_last_d  = (FIRST_IDX == LAST_IDX);
                    end
                end
                ST_STREAM: begin
                    if (out_valid_q && out_if.out_ready) begin
                        if (out_last_q) begin
                            state_d     = ST_READY;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end else begin
                            out_data_d  = rk_q[step_idx];
                            out_round_d = step_idx;
                            out_last_d  = (step_idx == LAST_IDX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            rk_q         <= '{default: '0};
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_round_q  <= 4'd0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rk_q         <= rk_d;
            busy_q       <= busy_d;
            keys_ready_q <= keys_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_round_q  <= out_round_d;
            out_last_q   <= out_last_d;
        end
    end

    assign busy             = busy_q;
    assign keys_ready       = keys_ready_q;
    assign dbg_state        = state_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_round = out_round_q;
    assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: a reverse-order instance and a forward-order
// instance sharing clock, reset and key load, checked against FIPS-197 round keys.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         stream_start;
    logic         stream_start_f;
    logic         busy, keys_ready;
    logic         busy_f, keys_ready_f;
    logic [1:0]   dbg_state, dbg_state_f;

    int n_checks = 0;
    int n_fail   = 0;

    aes_key_sched_ctrl_if rev_if ();
    aes_key_sched_ctrl_if fwd_if ();

    aes_key_sched_ctrl #(.REVERSE_ORDER(1'b1), .NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key_in       (key_in),
        .stream_start (stream_start),
        .busy         (busy),
        .keys_ready   (keys_ready),
        .dbg_state    (dbg_state),
        .out_if       (rev_if.master)
    );

    aes_key_sched_ctrl #(.REVERSE_ORDER(1'b0), .NR(10)) dut_fwd (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key_in       (key_in),
        .stream_start (stream_start_f),
        .busy         (busy_f),
        .keys_ready   (keys_ready_f),
        .dbg_state    (dbg_state_f),
        .out_if       (fwd_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [127:0] fips_rk [0:10];
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int r;
        int cyc;
        logic rdy;

        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst             = 1'b1;
        key_load        = 1'b0;
        key_in          = '0;
        stream_start    = 1'b0;
        stream_start_f  = 1'b0;
        rev_if.out_ready = 1'b1;
        fwd_if.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_state", 128'(dbg_state), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_keys_ready", 128'(keys_ready), 128'(0));
        check("rst_valid", 128'(rev_if.out_valid), 128'(0));
        check("rst_round", 128'(rev_if.out_round), 128'(0));
        check("rst_data", rev_if.out_data, 128'h0);
        check("rst_last", 128'(rev_if.out_last), 128'(0));

        // FIPS key: busy for 10 cycles, keys_ready at load+11, stream_start mid-expand ignored
        key_in   = FIPS_KEY;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("exp_busy_c%0d", i), 128'(busy), 128'(1));
            check($sformatf("exp_kr_c%0d", i), 128'(keys_ready), 128'(0));
            stream_start = (i == 3);
            step();
        end
        stream_start = 1'b0;
        check("ready_busy", 128'(busy), 128'(0));
        check("ready_keys_ready", 128'(keys_ready), 128'(1));
        check("ready_state", 128'(dbg_state), 128'(2));
        check("ready_no_valid", 128'(rev_if.out_valid), 128'(0));
        step();
        check("ready_no_valid2", 128'(rev_if.out_valid), 128'(0));

        // Full reverse stream with out_ready=1; stream_start mid-stream is ignored
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            check($sformatf("rev_valid_b%0d", b), 128'(rev_if.out_valid), 128'(1));
            check($sformatf("rev_round_b%0d", b), 128'(rev_if.out_round), 128'(10 - b));
            check($sformatf("rev_data_b%0d", b), rev_if.out_data, fips_rk[10 - b]);
            check($sformatf("rev_last_b%0d", b), 128'(rev_if.out_last), 128'(b == 10));
            check($sformatf("rev_kr_b%0d", b), 128'(keys_ready), 128'(1));
            stream_start = (b == 5);
            step();
        end
        stream_start = 1'b0;
        check("rev_end_valid", 128'(rev_if.out_valid), 128'(0));
        check("rev_end_state", 128'(dbg_state), 128'(2));

        // Random backpressure re-stream from retained keys
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        r   = 10;
        cyc = 0;
        while (r >= 0 && cyc < 300) begin
            check($sformatf("bp_valid_c%0d", cyc), 128'(rev_if.out_valid), 128'(1));
            check($sformatf("bp_round_c%0d", cyc), 128'(rev_if.out_round), 128'(r));
            check($sformatf("bp_data_c%0d", cyc), rev_if.out_data, fips_rk[r]);
            check($sformatf("bp_last_c%0d", cyc), 128'(rev_if.out_last), 128'(r == 0));
            rdy = 1'($urandom_range(0, 1));
            rev_if.out_ready = rdy;
            step();
            if (rdy) r--;
            cyc++;
        end
        check("bp_completed", 128'(r), 128'(-1));
        rev_if.out_ready = 1'b1;
        check("bp_end_valid", 128'(rev_if.out_valid), 128'(0));
        check("bp_end_state", 128'(dbg_state), 128'(2));

        // key_load mid-STREAM, then again mid-EXPAND with a new key
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        check("abort_round0", 128'(rev_if.out_round), 128'(10));
        step();
        check("abort_round1", 128'(rev_if.out_round), 128'(9));
        key_in   = '0;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        check("abort_valid", 128'(rev_if.out_valid), 128'(0));
        check("abort_last", 128'(rev_if.out_last), 128'(0));
        check("abort_busy", 128'(busy), 128'(1));
        check("abort_state", 128'(dbg_state), 128'(1));
        step();
        step();
        step();
        key_in   = KEY2;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("k2_kr_c%0d", i), 128'(keys_ready), 128'(0));
            step();
        end
        check("k2_keys_ready", 128'(keys_ready), 128'(1));
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            check($sformatf("k2_round_b%0d", b), 128'(rev_if.out_round), 128'(10 - b));
            if (b == 0) check("k2_rk10", rev_if.out_data, KEY2_RK10);
            if (b == 10) check("k2_rk0", rev_if.out_data, KEY2);
            check($sformatf("k2_last_b%0d", b), 128'(rev_if.out_last), 128'(b == 10));
            step();
        end
        check("k2_end_valid", 128'(rev_if.out_valid), 128'(0));

        // rst mid-EXPAND, then stream_start in IDLE
        key_in   = FIPS_KEY;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_state", 128'(dbg_state), 128'(0));
        check("mrst_busy", 128'(busy), 128'(0));
        check("mrst_keys_ready", 128'(keys_ready), 128'(0));
        check("mrst_valid", 128'(rev_if.out_valid), 128'(0));
        check("mrst_round", 128'(rev_if.out_round), 128'(0));
        check("mrst_data", rev_if.out_data, 128'h0);
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        check("idle_ss_valid", 128'(rev_if.out_valid), 128'(0));
        check("idle_ss_state", 128'(dbg_state), 128'(0));
        step();
        check("idle_ss_valid2", 128'(rev_if.out_valid), 128'(0));

        // Forward-order instance with the FIPS key
        key_in   = FIPS_KEY;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
        end
        check("fwd_keys_ready", 128'(keys_ready_f), 128'(1));
        stream_start_f = 1'b1;
        step();
        stream_start_f = 1'b0;
        for (int b = 0; b <= 10; b++) begin
            check($sformatf("fwd_valid_b%0d", b), 128'(fwd_if.out_valid), 128'(1));
            check($sformatf("fwd_round_b%0d", b), 128'(fwd_if.out_round), 128'(b));
            check($sformatf("fwd_data_b%0d", b), fwd_if.out_data, fips_rk[b]);
            check($sformatf("fwd_last_b%0d", b), 128'(fwd_if.out_last), 128'(b == 10));
            step();
        end
        check("fwd_end_valid", 128'(fwd_if.out_valid), 128'(0));
        check("fwd_end_state", 128'(dbg_state_f), 128'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
